// File: rtl/clause_bank_bcp_ctrl.sv
// Load/BCP sequencer for one bank of NUM_C clause rows: row loads, status scan, implication/conflict drive.
// Optional build macro MULTI_IMP_EN: fire every unit clause in a single IMPLY cycle.
module clause_bank_bcp_ctrl #(
    parameter int NUM_C      = 8,
    parameter int NUM_V      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int IDX_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [2*NUM_V-1:0]   load_lits,
    output logic [NUM_C-1:0]     wr_o,
    output logic [2*NUM_V-1:0]   lit_o,
    input  logic                 bcp_start,
    input  logic [2*NUM_C-1:0]   freelitcnt_i,
    input  logic [NUM_C-1:0]     clausesat_i,
    input  logic [NUM_C-1:0]     cclause_i,
    output logic [NUM_C-1:0]     imp_drv_o,
    output logic [NUM_C-1:0]     cclause_drv_o,
    output logic                 bcp_busy,
    output logic                 bcp_done,
    output logic                 bcp_conflict,
    output logic [IDX_W-1:0]     conflict_idx,
    output logic [7:0]           imp_cnt
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W:0] NUM_C_W = (IDX_W+1)'(NUM_C);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_IMPLY  = 3'd2,
        S_SETTLE = 3'd3,
        S_CONFL  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_C-1:0] m);
        low_idx = '0;
        for (int i = NUM_C-1; i >= 0; i--) begin
            if (m[i]) low_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_C-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [7:0] pop8(input logic [NUM_C-1:0] m);
        pop8 = 8'd0;
        for (int i = 0; i < NUM_C; i++) pop8 = pop8 + {7'd0, m[i]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s       = {1'b0, a} + {1'b0, b};
        sat_add = s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_settle_cnt, w_settle_nxt;
    logic [NUM_C-1:0]   r_wr, w_wr_nxt;
    logic [2*NUM_V-1:0] r_lit, w_lit_nxt;
    logic [NUM_C-1:0]   r_imp_drv, w_imp_drv_nxt;
    logic [NUM_C-1:0]   r_cdrv, w_cdrv_nxt;
    logic [7:0]         r_imp_cnt, w_imp_cnt_nxt;
    logic               r_conflict, w_conflict_nxt;
    logic [IDX_W-1:0]   r_conflict_idx, w_conflict_idx_nxt;
    logic               r_done, w_done_nxt;
    logic               r_busy, r_load_ready;
    logic [NUM_C-1:0]   w_conf_mask, w_unit_mask, w_imp_vec;

    // Per-row conflict and unit masks decoded from the cell status lines
    always_comb begin
        w_conf_mask = '0;
        w_unit_mask = '0;
        for (int c = 0; c < NUM_C; c++) begin
            w_conf_mask[c] = cclause_i[c] |
                             ((freelitcnt_i[2*c +: 2] == 2'b00) & ~clausesat_i[c]);
            w_unit_mask[c] = (freelitcnt_i[2*c +: 2] == 2'b01) & ~clausesat_i[c];
        end
    end

`ifdef MULTI_IMP_EN
    assign w_imp_vec = w_unit_mask;
`else
    assign w_imp_vec = onehot(low_idx(w_unit_mask));
`endif

    // Next-state and next-output decode; every output is registered from these
    always_comb begin
        w_state_nxt        = r_state;
        w_settle_nxt       = r_settle_cnt;
        w_wr_nxt           = '0;
        w_lit_nxt          = '0;
        w_imp_drv_nxt      = '0;
        w_cdrv_nxt         = '0;
        w_imp_cnt_nxt      = r_imp_cnt;
        w_conflict_nxt     = r_conflict;
        w_conflict_idx_nxt = r_conflict_idx;
        w_done_nxt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A load always wins over a simultaneous start
                if (load_valid) begin
                    if ({1'b0, load_idx} < NUM_C_W) begin
                        w_wr_nxt  = onehot(load_idx);
                        w_lit_nxt = load_lits;
                    end else begin
                        w_wr_nxt  = '0;
                    end
                end else if (bcp_start) begin
                    w_state_nxt        = S_SCAN;
                    w_imp_cnt_nxt      = 8'd0;
                    w_conflict_nxt     = 1'b0;
                    w_conflict_idx_nxt = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (|w_conf_mask) begin
                    w_state_nxt        = S_CONFL;
                    w_cdrv_nxt         = onehot(low_idx(w_conf_mask));
                    w_conflict_idx_nxt = low_idx(w_conf_mask);
                    w_conflict_nxt     = 1'b1;
                end else if (|w_unit_mask) begin
                    w_state_nxt   = S_IMPLY;
                    w_imp_drv_nxt = w_imp_vec;
                    w_imp_cnt_nxt = sat_add(r_imp_cnt, pop8(w_imp_vec));
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_IMPLY: begin
                w_state_nxt  = S_SETTLE;
                w_settle_nxt = CNT_W'(SETTLE_CYC - 1);
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_settle_nxt = r_settle_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_CONFL: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_settle_cnt   <= '0;
            r_wr           <= '0;
            r_lit          <= '0;
            r_imp_drv      <= '0;
            r_cdrv         <= '0;
            r_imp_cnt      <= 8'd0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_load_ready   <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_settle_cnt   <= w_settle_nxt;
            r_wr           <= w_wr_nxt;
            r_lit          <= w_lit_nxt;
            r_imp_drv      <= w_imp_drv_nxt;
            r_cdrv         <= w_cdrv_nxt;
            r_imp_cnt      <= w_imp_cnt_nxt;
            r_conflict     <= w_conflict_nxt;
            r_conflict_idx <= w_conflict_idx_nxt;
            r_done         <= w_done_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_load_ready   <= (w_state_nxt == S_IDLE);
        end
    end

    assign load_ready    = r_load_ready;
    assign wr_o          = r_wr;
    assign lit_o         = r_lit;
    assign imp_drv_o     = r_imp_drv;
    assign cclause_drv_o = r_cdrv;
    assign bcp_busy      = r_busy;
    assign bcp_done      = r_done;
    assign bcp_conflict  = r_conflict;
    assign conflict_idx  = r_conflict_idx;
    assign imp_cnt       = r_imp_cnt;
endmodule
